instr_exec_unit: RTL and testbench

// - Execute stage directly downstream of the instruction register: consumes one decoded

---
 rtl/instr_register_pkg.sv | 59 +++++
 rtl/instr_div_iter.sv | 65 ++++++
 rtl/instr_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_instr_exec_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared instruction types, execute FSM states and ALU helpers
package instr_register_pkg;

  typedef enum logic [3:0] {
    OPC_ZERO  = 4'd0,
    OPC_PASSA = 4'd1,
    OPC_PASSB = 4'd2,
    OPC_ADD   = 4'd3,
    OPC_SUB   = 4'd4,
    OPC_MULT  = 4'd5,
    OPC_DIV   = 4'd6,
    OPC_MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_result;
  typedef logic        [4:0]  address_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } exec_state_t;

  // Opcodes 8..15 have the top bit set and are not part of the instruction set.
  function automatic logic is_illegal_op(input opcode_t opc);
    return opc > OPC_MOD;
  endfunction

  function automatic logic is_div_op(input opcode_t opc);
    return (opc == OPC_DIV) || (opc == OPC_MOD);
  endfunction

  // Unsigned magnitude of a signed operand; -2^31 maps to 2^31, which still fits 32 bits.
  function automatic logic [31:0] magnitude(input operand_t v);
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Single-cycle arithmetic on sign-extended operands; DIV/MOD are not handled here.
  function automatic operand_result alu_single(input opcode_t opc, input operand_t a,
                                               input operand_t b);
    operand_result a64;
    operand_result b64;
    operand_result res;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    case (opc)
      OPC_PASSA: res = a64;
      OPC_PASSB: res = b64;
      OPC_ADD:   res = a64 + b64;
      OPC_SUB:   res = a64 - b64;
      OPC_MULT:  res = a64 * b64;
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_div_iter.sv
// rtl/instr_div_iter.sv - iterative unsigned restoring divider on 32-bit magnitudes
module instr_div_iter #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int ITERS = 32 / DIV_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [31:0]      quot_r;
  logic [32:0]      rem_r;
  logic [31:0]      divisor;
  logic [31:0]      quot_nxt;
  logic [32:0]      rem_nxt;

  // Resolve DIV_BITS_PER_CYCLE quotient bits: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    quot_nxt = quot_r;
    rem_nxt  = rem_r;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      rem_nxt  = {rem_nxt[31:0], quot_nxt[31]};
      quot_nxt = {quot_nxt[30:0], 1'b0};
      if (rem_nxt >= {1'b0, divisor}) begin
        rem_nxt     = rem_nxt - {1'b0, divisor};
        quot_nxt[0] = 1'b1;
      end
    end
  end

  // Load on start, then iterate until the count runs out; done holds until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      count   <= '0;
      quot_r  <= '0;
      rem_r   <= '0;
      divisor <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= CNT_W'(ITERS);
      quot_r  <= a_mag;
      rem_r   <= '0;
      divisor <= b_mag;
    end else if (running && (count != '0)) begin
      quot_r <= quot_nxt;
      rem_r  <= rem_nxt;
      count  <= count - CNT_W'(1);
    end
  end

  assign done = running && (count == '0);
  assign quot = quot_r;
  assign rem  = rem_r[31:0];

endmodule

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - execute stage: single-cycle ALU ops plus iterative signed DIV/MOD
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int                   DIV_BITS_PER_CYCLE = 1,
  parameter int                   COUNT_W            = 16,
  parameter logic signed [63:0]   DIV0_RESULT        = 64'sd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  opcode_t            in_opc,
  input  operand_t           in_op_a,
  input  operand_t           in_op_b,
  input  address_t           in_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output opcode_t            out_opc,
  output address_t           out_addr,
  output operand_result      out_result,
  output logic               out_err,
  output logic               busy,
  output logic [COUNT_W-1:0] done_count
);

  exec_state_t   state;
  exec_state_t   next_state;
  opcode_t       opc_r;
  operand_t      a_r;
  operand_t      b_r;
  address_t      addr_r;
  logic          accept;
  logic          div_start;
  logic          div_done;
  logic [31:0]   div_quot;
  logic [31:0]   div_rem;
  operand_result exec_result;
  logic          exec_err;
  operand_result div_result;

  assign accept = in_valid && in_ready;

  instr_div_iter #(
    .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (div_start),
    .a_mag  (magnitude(a_r)),
    .b_mag  (magnitude(b_r)),
    .done   (div_done),
    .quot   (div_quot),
    .rem    (div_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; DONE may hand straight over to EXEC when a new instruction arrives.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = div_start ? DIVIDE : DONE;
      DIVIDE:  if (div_done) next_state = DONE;
      DONE:    if (accept) next_state = EXEC;
               else if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; in_ready is gated by reset_n so it reads 0 while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset_n;
        busy     = 1'b0;
      end
      EXEC:    div_start = is_div_op(opc_r) && (b_r != '0);
      DONE:    in_ready = reset_n && out_ready;
      default: ;
    endcase
  end

  // Result of the EXEC cycle for everything that does not need the divider.
  always_comb begin
    exec_result = '0;
    exec_err    = 1'b0;
    if (is_illegal_op(opc_r)) begin
      exec_err = 1'b1;
    end else if (is_div_op(opc_r)) begin
      exec_result = DIV0_RESULT;
      exec_err    = 1'b1;
    end else begin
      exec_result = alu_single(opc_r, a_r, b_r);
    end
  end

  // Sign fixup: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    div_result = '0;
    if (opc_r == OPC_DIV) begin
      div_result = {32'd0, div_quot};
      if (a_r[31] ^ b_r[31]) div_result = -div_result;
    end else begin
      div_result = {32'd0, div_rem};
      if (a_r[31]) div_result = -div_result;
    end
  end

  // Capture operands on accept and register results; out_* hold until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opc_r      <= OPC_ZERO;
      a_r        <= '0;
      b_r        <= '0;
      addr_r     <= '0;
      out_valid  <= 1'b0;
      out_opc    <= OPC_ZERO;
      out_addr   <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      if (accept) begin
        opc_r  <= in_opc;
        a_r    <= in_op_a;
        b_r    <= in_op_b;
        addr_r <= in_addr;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == EXEC && !div_start) begin
        out_valid  <= 1'b1;
        out_opc    <= opc_r;
        out_addr   <= addr_r;
        out_result <= exec_result;
        out_err    <= exec_err;
      end else if (state == DIVIDE && div_done) begin
        out_valid  <= 1'b1;
        out_opc    <= opc_r;
        out_addr   <= addr_r;
        out_result <= div_result;
        out_err    <= 1'b0;
      end
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_count <= '0;
    end else if (out_valid && out_ready && (done_count != '1)) begin
      done_count <= done_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - self-checking bench for instr_exec_unit against a behavioural model
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  opcode_t       in_opc = OPC_ZERO;
  operand_t      in_op_a = '0;
  operand_t      in_op_b = '0;
  address_t      in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  opcode_t       out_opc;
  address_t      out_addr;
  operand_result out_result;
  logic          out_err;
  logic          busy;
  logic [CW-1:0] done_count;

  int total = 0;
  int bad = 0;
  int hs = 0;
  bit pending = 0;

  always #5 clk = ~clk;

  instr_exec_unit #(
    .DIV_BITS_PER_CYCLE(1),
    .COUNT_W(CW),
    .DIV0_RESULT(64'sd0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc), .out_addr(out_addr),
    .out_result(out_result), .out_err(out_err), .busy(busy), .done_count(done_count)
  );

  function automatic int exp_count();
    return (hs > SAT) ? SAT : hs;
  endfunction

  // One clock edge; a result the bench has seen is consumed if out_ready was high at the edge.
  task automatic tick();
    @(posedge clk);
    if (pending && out_ready) begin
      hs++;
      pending = 0;
    end
    #1;
  endtask

  // Behavioural reference: plain 64-bit arithmetic; latency counts edges including the accept edge.
  task automatic ref_model(input logic [3:0] opc, input int a, input int b,
                           output longint res, output bit err, output int lat);
    longint a64;
    longint b64;
    a64 = a;
    b64 = b;
    res = 0;
    err = 0;
    lat = 2;
    case (opc)
      4'd0: res = 0;
      4'd1: res = a64;
      4'd2: res = b64;
      4'd3: res = a64 + b64;
      4'd4: res = a64 - b64;
      4'd5: res = a64 * b64;
      4'd6, 4'd7: begin
        if (b == 0) begin
          err = 1;
        end else begin
          res = (opc == 4'd6) ? (a64 / b64) : (a64 % b64);
          lat = 35;
        end
      end
      default: err = 1;
    endcase
  endtask

  // Present one instruction and wait (bounded) for its result; leaves out_* for the caller to inspect.
  task automatic exec_op(input logic [3:0] opc, input int a, input int b, input logic [4:0] addr,
                         output bit rdy, output bit rdy_wait, output int lat);
    in_valid = 1'b1;
    in_opc   = opcode_t'(opc);
    in_op_a  = a;
    in_op_b  = b;
    in_addr  = addr;
    rdy      = in_ready;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    rdy_wait = 0;
    while (!out_valid && lat < 100) begin
      rdy_wait |= in_ready;
      tick();
      lat++;
    end
    if (out_valid) pending = 1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0) begin bad++; $display("FAIL reset_flags: valid=%b busy=%b err=%b want 0", out_valid, busy, out_err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_held: got %b want 0", in_ready); end
    total++; if (out_result !== 64'sd0 || done_count !== '0) begin bad++; $display("FAIL reset_values: result=%0d count=%0d want 0", out_result, done_count); end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_add();
    bit rdy, rw;
    int lat;
    exec_op(4'd3, 7, -10, 5'd3, rdy, rw, lat);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", rdy); end
    total++; if (lat != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
    total++; if (out_result !== -64'sd3 || out_err !== 1'b0) begin bad++; $display("FAIL add_result: got %0d err=%b want -3 err=0", out_result, out_err); end
    total++; if (out_addr !== 5'd3 || out_opc !== OPC_ADD) begin bad++; $display("FAIL add_tag: addr=%0d opc=%0d want 3/3", out_addr, out_opc); end
    tick();
    total++; if (out_valid !== 1'b0 || int'(done_count) != exp_count()) begin bad++; $display("FAIL add_handshake: valid=%b count=%0d want 0/%0d", out_valid, done_count, exp_count()); end
  endtask

  task automatic test_back_to_back();
    bit rdy, rw;
    int lat;
    exec_op(4'd5, 32'h8000_0000, 32'h8000_0000, 5'd1, rdy, rw, lat);
    total++; if (out_result !== 64'sh4000_0000_0000_0000 || lat != 2) begin bad++; $display("FAIL mult_result: got %h lat=%0d want 4000000000000000 lat=2", out_result, lat); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_in_done: got %b want 1", in_ready); end
    exec_op(4'd2, 0, -1, 5'd2, rdy, rw, lat);
    total++; if (rdy !== 1'b1 || lat != 2) begin bad++; $display("FAIL b2b_accept: rdy=%b lat=%0d want 1/2", rdy, lat); end
    total++; if (out_result !== -64'sd1 || out_addr !== 5'd2) begin bad++; $display("FAIL b2b_passb: got %0d addr=%0d want -1/2", out_result, out_addr); end
    total++; if (int'(done_count) != exp_count()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", done_count, exp_count()); end
    tick();
  endtask

  task automatic test_divide();
    logic [3:0] opcs [4] = '{4'd6, 4'd7, 4'd6, 4'd7};
    int         as   [4] = '{-7, -7, 32'h8000_0000, 32'h8000_0000};
    int         bs   [4] = '{2, 2, -1, -1};
    bit rdy, rw, err;
    int lat, elat;
    longint res;
    for (int i = 0; i < 4; i++) begin
      ref_model(opcs[i], as[i], bs[i], res, err, elat);
      exec_op(opcs[i], as[i], bs[i], 5'(i + 8), rdy, rw, lat);
      total++; if (lat != elat) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, elat); end
      total++; if (out_result !== res || out_err !== err) begin bad++; $display("FAIL div_result[%0d]: got %0d err=%b want %0d err=%b", i, out_result, out_err, res, err); end
      total++; if (rw !== 1'b0) begin bad++; $display("FAIL div_in_ready_busy[%0d]: got %b want 0", i, rw); end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [3:0] opcs [4] = '{4'd6, 4'd7, 4'hF, 4'h8};
    int         bs   [4] = '{0, 0, 4, 9};
    bit rdy, rw, err;
    int lat, elat;
    longint res;
    for (int i = 0; i < 4; i++) begin
      ref_model(opcs[i], 5, bs[i], res, err, elat);
      exec_op(opcs[i], 5, bs[i], 5'd20, rdy, rw, lat);
      total++; if (lat != elat) begin bad++; $display("FAIL err_latency[%0d]: got %0d want %0d", i, lat, elat); end
      total++; if (out_result !== res || out_err !== err) begin bad++; $display("FAIL err_result[%0d]: got %0d err=%b want %0d err=%b", i, out_result, out_err, res, err); end
      tick();
    end
  endtask

  task automatic test_stall();
    bit rdy, rw;
    int lat, cnt0;
    out_ready = 1'b0;
    exec_op(4'd3, 1, 2, 5'd7, rdy, rw, lat);
    cnt0 = exp_count();
    in_valid = 1'b1;
    in_opc   = OPC_SUB;
    in_op_a  = 10;
    in_op_b  = 4;
    in_addr  = 5'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== 64'sd3 || out_addr !== 5'd7) begin bad++; $display("FAIL stall_hold[%0d]: valid=%b result=%0d addr=%0d want 1/3/7", i, out_valid, out_result, out_addr); end
      total++; if (in_ready !== 1'b0 || int'(done_count) != cnt0) begin bad++; $display("FAIL stall_blocked[%0d]: in_ready=%b count=%0d want 0/%0d", i, in_ready, done_count, cnt0); end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || int'(done_count) != exp_count()) begin bad++; $display("FAIL stall_release: valid=%b count=%0d want 0/%0d", out_valid, done_count, exp_count()); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 64'sd6 || out_addr !== 5'd9) begin bad++; $display("FAIL stall_held_input: valid=%b result=%0d addr=%0d want 1/6/9", out_valid, out_result, out_addr); end
    if (out_valid) pending = 1;
    tick();
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return int'(32'h8000_0000);
      2:       return -1;
      3:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom());
    endcase
  endfunction

  task automatic test_random();
    bit rdy, rw, err;
    int lat, elat, a, b;
    longint res;
    logic [3:0] opc;
    logic [4:0] addr;
    for (int i = 0; i < 40; i++) begin
      opc  = 4'($urandom_range(0, 15));
      a    = pick_operand();
      b    = pick_operand();
      addr = 5'($urandom_range(0, 31));
      ref_model(opc, a, b, res, err, elat);
      exec_op(opc, a, b, addr, rdy, rw, lat);
      total++; if (lat != elat || rdy !== 1'b1) begin bad++; $display("FAIL rand_timing[%0d]: lat=%0d rdy=%b want %0d/1 opc=%0d", i, lat, rdy, elat, opc); end
      total++; if (out_result !== res || out_err !== err) begin bad++; $display("FAIL rand_result[%0d]: opc=%0d a=%0d b=%0d got %0d err=%b want %0d err=%b", i, opc, a, b, out_result, out_err, res, err); end
      total++; if (out_addr !== addr || out_opc !== opc) begin bad++; $display("FAIL rand_tag[%0d]: addr=%0d opc=%0d want %0d/%0d", i, out_addr, out_opc, addr, opc); end
      if ($urandom_range(0, 2) == 0) tick();
    end
    tick();
    total++; if (int'(done_count) != exp_count() || exp_count() != SAT) begin bad++; $display("FAIL count_saturate: got %0d want %0d", done_count, SAT); end
  endtask

  task automatic test_reset_mid_divide();
    bit rdy, rw;
    int lat;
    in_valid = 1'b1;
    in_opc   = OPC_DIV;
    in_op_a  = 1000;
    in_op_b  = 7;
    in_addr  = 5'd4;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (9) tick();
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL middiv_busy: busy=%b valid=%b want 1/0", busy, out_valid); end
    reset_n = 1'b0;
    #1;
    hs = 0;
    pending = 0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL middiv_reset_flags: valid=%b busy=%b ready=%b want 0", out_valid, busy, in_ready); end
    total++; if (done_count !== '0 || out_result !== 64'sd0 || out_addr !== 5'd0) begin bad++; $display("FAIL middiv_reset_values: count=%0d result=%0d addr=%0d want 0", done_count, out_result, out_addr); end
    tick();
    reset_n = 1'b1;
    #1;
    exec_op(4'd3, 1, 1, 5'd11, rdy, rw, lat);
    total++; if (out_result !== 64'sd2 || lat != 2 || rdy !== 1'b1) begin bad++; $display("FAIL post_reset_add: got %0d lat=%0d rdy=%b want 2/2/1", out_result, lat, rdy); end
    total++; if (done_count !== '0) begin bad++; $display("FAIL post_reset_count_before: got %0d want 0", done_count); end
    tick();
    total++; if (int'(done_count) != 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", done_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_divide();
    test_errors();
    test_stall();
    test_random();
    test_reset_mid_divide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
